// File: rtl/wellfilter_bias_seq.sv
// Well-filter switch sequencer: enables masked channels one at a time with settle and debounce.
// Optional CHECK timeout is enabled by defining WELLFLT_TIMEOUT_EN.
module wellfilter_bias_seq #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int DEB    = 3,
  parameter int TO_CYC = 255,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [N_CH-1:0]  ch_mask_i,
  input  logic [CNT_W-1:0] settle_cnt_i,
  input  logic [N_CH-1:0]  ok_i,
  output logic [N_CH-1:0]  flt_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [CH_W-1:0]  fault_ch_o
);

  localparam int DEB_W = $clog2(DEB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SETTLE,
    S_CHECK,
    S_DONE,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  en_q, en_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]  fch_q, fch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [N_CH-1:0]  sync1_q, ok_s;
`ifdef WELLFLT_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0]  to_q, to_d;
`endif

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [CH_W:0] next_set(
    input logic [N_CH-1:0] m,
    input int              from
  );
    logic [CH_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  logic [CH_W:0]   nx_first, nx_next, lost_first;
  logic [N_CH-1:0] lost;

  assign nx_first   = next_set(ch_mask_i, 0);
  assign nx_next    = next_set(mask_q, int'(idx_q) + 1);
  assign lost       = en_q & ~ok_s;
  assign lost_first = next_set(lost, 0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    en_d    = en_q;
    idx_d   = idx_q;
    fch_d   = fch_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
`ifdef WELLFLT_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          mask_d = ch_mask_i;
          if (nx_first[CH_W]) begin
            idx_d   = nx_first[CH_W-1:0];
            state_d = S_ENABLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ENABLE: begin
        en_d    = en_q | (N_CH'(1) << idx_q);
        cnt_d   = settle_cnt_i;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          deb_d   = '0;
`ifdef WELLFLT_TIMEOUT_EN
          to_d    = '0;
`endif
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CHECK: begin
`ifdef WELLFLT_TIMEOUT_EN
        to_d = to_q + 1'b1;
`endif
        if (ok_s[idx_q] && deb_q == DEB_W'(DEB - 1)) begin
          deb_d = '0;
          if (nx_next[CH_W]) begin
            idx_d   = nx_next[CH_W-1:0];
            state_d = S_ENABLE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          deb_d = ok_s[idx_q] ? deb_q + 1'b1 : '0;
`ifdef WELLFLT_TIMEOUT_EN
          if (to_q == TO_W'(TO_CYC - 1)) begin
            fch_d   = idx_q;
            en_d    = '0;
            state_d = S_FAULT;
          end
`endif
        end
      end
      S_DONE: begin
        if (|lost) begin
          fch_d   = lost_first[CH_W-1:0];
          en_d    = '0;
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping req_i outranks any other transition
    if (state_q != S_IDLE && !req_i) begin
      state_d = S_IDLE;
      mask_d  = '0;
      en_d    = '0;
      idx_d   = '0;
      fch_d   = '0;
      cnt_d   = '0;
      deb_d   = '0;
`ifdef WELLFLT_TIMEOUT_EN
      to_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      fch_q   <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      sync1_q <= '0;
      ok_s    <= '0;
`ifdef WELLFLT_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      fch_q   <= fch_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      sync1_q <= ok_i;
      ok_s    <= sync1_q;
`ifdef WELLFLT_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign flt_en_o   = en_q;
  assign busy_o     = (state_q == S_ENABLE) ||
                      (state_q == S_SETTLE) ||
                      (state_q == S_CHECK);
  assign done_o     = (state_q == S_DONE);
  assign fault_o    = (state_q == S_FAULT);
  assign fault_ch_o = fch_q;

endmodule
